// File: rtl/axis_frame_arbiter_if.sv
// AXI4-Stream video link: tuser marks start-of-frame, tlast marks end-of-line.
// The master drives payload and valid; the slave drives ready.
interface axis_frame_arbiter_if #(
   parameter int DSIZE = 24
);
   logic [DSIZE-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tuser;
   logic             tlast;

   modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one AXIS video output between two sources.
// Grants switch only at frame boundaries; ungranted non-SOF data is flushed while idle.
//
// state   | meaning
// IDLE    | no owner; drop non-SOF beats, hold SOF at the head, pick the next owner
// GRANTED | sel owns the output; zero-latency pass-through until lines_tgt EOLs
module axis_frame_arbiter #(
   parameter int DSIZE = 24,
   parameter int LSIZE = 12
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [LSIZE-1:0]      vactive,
   axis_frame_arbiter_if.slave   s0,
   axis_frame_arbiter_if.slave   s1,
   axis_frame_arbiter_if.master  m,
   output logic [1:0]            grant,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  sof_err,
   output logic [15:0]           frame_cnt
);

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic             sel, sel_nxt;
   logic             last_grant, last_grant_nxt;
   logic             first_beat, first_beat_nxt;
   logic             run;
   logic [LSIZE-1:0] line_cnt, line_cnt_nxt;
   logic [LSIZE-1:0] lines_tgt, lines_tgt_nxt;
   logic             frame_done_nxt, sof_err_nxt;
   logic [15:0]      frame_cnt_nxt;

   logic             req0, req1;
   logic [DSIZE-1:0] sel_data;
   logic             sel_valid, sel_user, sel_last;
   logic             beat, mid_sof, last_line;
   logic [LSIZE-1:0] cnt_base;

   assign req0      = s0.tvalid & s0.tuser & enable;
   assign req1      = s1.tvalid & s1.tuser & enable;
   assign sel_data  = sel ? s1.tdata  : s0.tdata;
   assign sel_valid = sel ? s1.tvalid : s0.tvalid;
   assign sel_user  = sel ? s1.tuser  : s0.tuser;
   assign sel_last  = sel ? s1.tlast  : s0.tlast;
   assign beat      = (state == GRANTED) & sel_valid & m.tready;
   assign mid_sof   = beat & sel_user & ~first_beat;
   // A mid-frame SOF restarts the line count, so its own EOL counts as line one.
   assign cnt_base  = mid_sof ? '0 : line_cnt;
   assign last_line = (cnt_base == lines_tgt - LSIZE'(1));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= 1'b0;
         last_grant <= 1'b1;
         first_beat <= 1'b0;
         run        <= 1'b0;
         line_cnt   <= '0;
         lines_tgt  <= LSIZE'(1);
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         sel        <= sel_nxt;
         last_grant <= last_grant_nxt;
         first_beat <= first_beat_nxt;
         run        <= 1'b1;
         line_cnt   <= line_cnt_nxt;
         lines_tgt  <= lines_tgt_nxt;
         frame_done <= frame_done_nxt;
         sof_err    <= sof_err_nxt;
         frame_cnt  <= frame_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      sel_nxt        = sel;
      last_grant_nxt = last_grant;
      first_beat_nxt = first_beat;
      line_cnt_nxt   = line_cnt;
      lines_tgt_nxt  = lines_tgt;
      frame_done_nxt = 1'b0;
      sof_err_nxt    = 1'b0;
      frame_cnt_nxt  = frame_cnt;
      case (state)
         IDLE: begin
            if (req0 | req1) begin
               state_nxt      = GRANTED;
               sel_nxt        = (req0 & req1) ? ~last_grant : req1;
               lines_tgt_nxt  = (vactive == '0) ? LSIZE'(1) : vactive;
               line_cnt_nxt   = '0;
               first_beat_nxt = 1'b1;
            end
         end
         GRANTED: begin
            if (beat) begin
               first_beat_nxt = 1'b0;
               sof_err_nxt    = mid_sof;
               line_cnt_nxt   = cnt_base;
               if (sel_last) begin
                  if (last_line) begin
                     state_nxt      = IDLE;
                     last_grant_nxt = sel;
                     line_cnt_nxt   = '0;
                     frame_done_nxt = 1'b1;
                     frame_cnt_nxt  = frame_cnt + 16'd1;
                  end else begin
                     line_cnt_nxt = cnt_base + LSIZE'(1);
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Payload and valid are muxed by sel only, never by m.tready.
   always_comb begin
      grant     = 2'b00;
      busy      = 1'b0;
      m.tdata   = sel_data;
      m.tuser   = sel_user;
      m.tlast   = sel_last;
      m.tvalid  = 1'b0;
      s0.tready = 1'b0;
      s1.tready = 1'b0;
      if (state == GRANTED) begin
         busy     = 1'b1;
         grant    = sel ? 2'b10 : 2'b01;
         m.tvalid = sel_valid;
         if (sel) s1.tready = m.tready;
         else     s0.tready = m.tready;
      end else begin
         s0.tready = run & s0.tvalid & ~s0.tuser;
         s1.tready = run & s1.tvalid & ~s1.tuser;
      end
   end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: queue-driven sources, output capture,
// hand-built expected beat order.
module tb_axis_frame_arbiter;
   localparam int DSIZE = 24;
   localparam int LSIZE = 12;

   logic             clock = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic [LSIZE-1:0] vactive = '0;
   logic [1:0]       grant;
   logic             busy, frame_done, sof_err;
   logic [15:0]      frame_cnt;

   axis_frame_arbiter_if #(.DSIZE(DSIZE)) s0_if ();
   axis_frame_arbiter_if #(.DSIZE(DSIZE)) s1_if ();
   axis_frame_arbiter_if #(.DSIZE(DSIZE)) m_if ();

   axis_frame_arbiter #(.DSIZE(DSIZE), .LSIZE(LSIZE)) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .enable     (enable),
      .vactive    (vactive),
      .s0         (s0_if),
      .s1         (s1_if),
      .m          (m_if),
      .grant      (grant),
      .busy       (busy),
      .frame_done (frame_done),
      .sof_err    (sof_err),
      .frame_cnt  (frame_cnt)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [DSIZE-1:0] d;
      logic             u;
      logic             l;
   } beat_t;

   beat_t      q0[$], q1[$], out_q[$], exp_q[$];
   logic [1:0] gseq[$];
   int         gaps[$];
   int         n_cmp = 0, n_err = 0;
   int         cyc, fd_cnt, se_cnt, fd_cyc, last_tl_cyc, drops, ng_err, stall_err, stalls, idle_run;
   bit         fire0, fire1, rnd_rdy, had_busy, prev_busy, prev_v, prev_r;
   logic [DSIZE-1:0] prev_d;
   logic       prev_u, prev_l;
   logic [1:0] prev_grant;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic beat_t mk_beat(input int src, input int fid, input int l, input int p, input int ppl);
      beat_t b;
      b.d = {4'(src), 4'(fid), 8'(l), 8'(p)};
      b.u = (l == 0) && (p == 0);
      b.l = (p == ppl - 1);
      return b;
   endfunction

   task automatic push_frame(input int src, input int fid, input int lines, input int ppl);
      for (int l = 0; l < lines; l++)
         for (int p = 0; p < ppl; p++)
            if (src == 0) q0.push_back(mk_beat(src, fid, l, p, ppl));
            else          q1.push_back(mk_beat(src, fid, l, p, ppl));
   endtask

   task automatic expect_frame(input int src, input int fid, input int lines, input int ppl);
      for (int l = 0; l < lines; l++)
         for (int p = 0; p < ppl; p++)
            exp_q.push_back(mk_beat(src, fid, l, p, ppl));
   endtask

   task automatic drive_sources();
      if (q0.size() > 0) begin
         s0_if.tvalid = 1'b1;
         {s0_if.tdata, s0_if.tuser, s0_if.tlast} = q0[0];
      end else begin
         s0_if.tvalid = 1'b0;
         {s0_if.tdata, s0_if.tuser, s0_if.tlast} = '0;
      end
      if (q1.size() > 0) begin
         s1_if.tvalid = 1'b1;
         {s1_if.tdata, s1_if.tuser, s1_if.tlast} = q1[0];
      end else begin
         s1_if.tvalid = 1'b0;
         {s1_if.tdata, s1_if.tuser, s1_if.tlast} = '0;
      end
   endtask

   // One clock: update drive just after the edge, observe at the falling edge.
   task automatic step();
      beat_t b;
      @(posedge clock);
      #1;
      if (fire0 && q0.size() > 0) void'(q0.pop_front());
      if (fire1 && q1.size() > 0) void'(q1.pop_front());
      cyc++;
      if (rnd_rdy) m_if.tready = 1'($urandom_range(0, 1));
      drive_sources();
      @(negedge clock);
      fire0 = s0_if.tvalid & s0_if.tready;
      fire1 = s1_if.tvalid & s1_if.tready;
      if (m_if.tvalid && m_if.tready) begin
         b.d = m_if.tdata; b.u = m_if.tuser; b.l = m_if.tlast;
         out_q.push_back(b);
         if (m_if.tlast) last_tl_cyc = cyc;
      end
      if ((fire0 || fire1) && !m_if.tvalid) drops++;
      if (m_if.tvalid && !m_if.tready) stalls++;
      if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
      if (sof_err) se_cnt++;
      if (grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant);
      if ((grant == 2'b01 && s1_if.tready) || (grant == 2'b10 && s0_if.tready)) ng_err++;
      if (prev_v && !prev_r &&
          (!m_if.tvalid || m_if.tdata !== prev_d || m_if.tuser !== prev_u || m_if.tlast !== prev_l))
         stall_err++;
      if (!busy) idle_run++;
      else begin
         if (!prev_busy && had_busy) gaps.push_back(idle_run);
         idle_run = 0;
         had_busy = 1'b1;
      end
      prev_busy = busy; prev_grant = grant;
      prev_v = m_if.tvalid; prev_r = m_if.tready;
      prev_d = m_if.tdata; prev_u = m_if.tuser; prev_l = m_if.tlast;
   endtask

   task automatic start_test();
      rst_n = 1'b0;
      enable = 1'b0;
      rnd_rdy = 1'b0;
      m_if.tready = 1'b0;
      q0.delete(); q1.delete(); out_q.delete(); exp_q.delete(); gseq.delete(); gaps.delete();
      fire0 = 0; fire1 = 0;
      cyc = 0; fd_cnt = 0; se_cnt = 0; fd_cyc = -100; last_tl_cyc = 0; drops = 0;
      ng_err = 0; stall_err = 0; stalls = 0; idle_run = 0;
      had_busy = 0; prev_busy = 0; prev_v = 0; prev_r = 0; prev_grant = 2'b00;
      drive_sources();
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
   endtask

   task automatic compare_out(input string tag);
      int nbad;
      nbad = 0;
      check_val({tag, "_nbeats"}, out_q.size(), exp_q.size());
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         if (out_q[i] !== exp_q[i]) nbad++;
      check_val({tag, "_data"}, nbad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gbad, gnt_seen;
      // reset state, with a non-SOF beat offered during reset
      m_if.tready = 1'b1;
      s0_if.tvalid = 1'b1; s0_if.tuser = 1'b0; s0_if.tlast = 1'b0; s0_if.tdata = 24'h123456;
      s1_if.tvalid = 1'b0; s1_if.tuser = 1'b0; s1_if.tlast = 1'b0; s1_if.tdata = '0;
      #2;
      check_val("rst_grant", grant, 2'b00);
      check_val("rst_busy", busy, 0);
      check_val("rst_frame_done", frame_done, 0);
      check_val("rst_sof_err", sof_err, 0);
      check_val("rst_frame_cnt", frame_cnt, 0);
      check_val("rst_m_tvalid", m_if.tvalid, 0);
      check_val("rst_s0_tready", s0_if.tready, 0);

      // 1: single source, 3 lines x 4 pixels
      start_test();
      vactive = 3; enable = 1'b1; m_if.tready = 1'b1;
      push_frame(0, 1, 3, 4); expect_frame(0, 1, 3, 4);
      gbad = 0;
      for (int i = 0; i < 300 && fd_cnt < 1; i++) begin
         step();
         if (busy && grant != 2'b01) gbad++;
      end
      repeat (3) step();
      compare_out("t1");
      check_val("t1_grant_bad", gbad, 0);
      check_val("t1_ngrants", gseq.size(), 1);
      check_val("t1_grant", gseq.size() > 0 ? gseq[0] : 2'b00, 2'b01);
      check_val("t1_fd_cnt", fd_cnt, 1);
      check_val("t1_fd_delay", fd_cyc - last_tl_cyc, 1);
      check_val("t1_frame_cnt", frame_cnt, 1);

      // 2: both sources contend, round-robin per frame
      start_test();
      vactive = 2; enable = 1'b1; m_if.tready = 1'b1;
      push_frame(0, 1, 2, 3); push_frame(0, 2, 2, 3);
      push_frame(1, 1, 2, 3); push_frame(1, 2, 2, 3);
      expect_frame(0, 1, 2, 3); expect_frame(1, 1, 2, 3);
      expect_frame(0, 2, 2, 3); expect_frame(1, 2, 2, 3);
      for (int i = 0; i < 600 && fd_cnt < 4; i++) step();
      repeat (3) step();
      compare_out("t2");
      check_val("t2_ngrants", gseq.size(), 4);
      for (int i = 0; i < gseq.size() && i < 4; i++)
         check_val($sformatf("t2_grant%0d", i), gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      check_val("t2_ngaps", gaps.size(), 3);
      for (int i = 0; i < gaps.size(); i++)
         check_val($sformatf("t2_gap%0d", i), gaps[i], 1);
      check_val("t2_frame_cnt", frame_cnt, 4);

      // 3: idle flush of non-SOF beats, SOF held until grant
      start_test();
      vactive = 1; enable = 1'b1; m_if.tready = 1'b1;
      for (int i = 0; i < 5; i++) q1.push_back('{d: 24'hEEEE00 + 24'(i), u: 1'b0, l: 1'b0});
      push_frame(1, 3, 1, 4); expect_frame(1, 3, 1, 4);
      for (int i = 0; i < 300 && fd_cnt < 1; i++) step();
      repeat (2) step();
      check_val("t3_drops", drops, 5);
      compare_out("t3");
      check_val("t3_first_tuser", out_q.size() > 0 ? out_q[0].u : 1'b0, 1);
      check_val("t3_grant", gseq.size() > 0 ? gseq[0] : 2'b00, 2'b10);

      // 4: mid-frame SOF after 2 lines restarts the count
      start_test();
      vactive = 4; enable = 1'b1; m_if.tready = 1'b1;
      push_frame(0, 4, 2, 4); push_frame(0, 5, 4, 4);
      expect_frame(0, 4, 2, 4); expect_frame(0, 5, 4, 4);
      for (int i = 0; i < 300 && fd_cnt < 1; i++) step();
      repeat (3) step();
      check_val("t4_sof_err", se_cnt, 1);
      check_val("t4_fd_cnt", fd_cnt, 1);
      compare_out("t4");
      check_val("t4_fd_delay", fd_cyc - last_tl_cyc, 1);
      check_val("t4_frame_cnt", frame_cnt, 1);

      // 5: random backpressure
      start_test();
      vactive = 2; enable = 1'b1; m_if.tready = 1'b1; rnd_rdy = 1'b1;
      push_frame(0, 6, 2, 5); push_frame(1, 7, 2, 5);
      expect_frame(0, 6, 2, 5); expect_frame(1, 7, 2, 5);
      for (int i = 0; i < 800 && fd_cnt < 2; i++) step();
      repeat (3) step();
      compare_out("t5");
      check_val("t5_nongrant_tready", ng_err, 0);
      check_val("t5_stall_stable", stall_err, 0);
      check_val("t5_saw_stall", stalls > 0, 1);
      check_val("t5_frame_cnt", frame_cnt, 2);

      // 6: reset mid-frame, then gated by enable
      start_test();
      vactive = 2; enable = 1'b1; m_if.tready = 1'b1;
      push_frame(0, 8, 2, 4);
      for (int i = 0; i < 100 && out_q.size() < 6; i++) step();
      check_val("t6_mid_frame", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_rst_grant", grant, 2'b00);
      check_val("t6_rst_busy", busy, 0);
      check_val("t6_rst_m_tvalid", m_if.tvalid, 0);
      check_val("t6_rst_s0_tready", s0_if.tready, 0);
      q0.delete(); fire0 = 0; fire1 = 0;
      enable = 1'b0;
      push_frame(1, 9, 1, 3);
      @(posedge clock);
      #1 rst_n = 1'b1;
      gnt_seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (grant != 2'b00) gnt_seen++;
      end
      check_val("t6_no_grant", gnt_seen, 0);
      check_val("t6_no_fd", fd_cnt, 0);
      check_val("t6_sof_held", s1_if.tready, 0);
      check_val("t6_frame_cnt", frame_cnt, 0);
      enable = 1'b1;
      step();
      check_val("t6_grant_after_en", grant, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
